// File: rtl/bin_to_dyn_7seg.sv
// bin_to_dyn_7seg
//   Binary to decimal converter driving a dynamic (time-multiplexed)
//   seven-segment display.
//
//   - Iterative shift-add-3 (double-dabble) converter FSM:
//     IDLE -> CONV (w_bin cycles) -> LOAD -> IDLE, free-running,
//     one conversion every w_bin+2 cycles.
//   - Snapshot display register, written only in LOAD, so the scanner
//     never shows a half-converted value.
//   - Digit scanner: one digit every P = clk_mhz*1e6/refresh_hz cycles,
//     registered one-hot digit select and segment outputs.
//
//   Optional build macro:
//     BIN_TO_DYN_7SEG_LEADING_ZERO_BLANK_EN
//       defined   : zero digits above the most significant nonzero digit
//                   are blanked (digit 0 is never blanked).
//       undefined : every digit shows its decoded value, leading zeros too.
//
//   Segment bus abcdefgh: bit7 = a ... bit1 = g, bit0 = h (dp, held 0).

module bin_to_dyn_7seg #(
    parameter int clk_mhz    = 50,
    parameter int refresh_hz = 1000,
    parameter int w_bin      = 6,
    parameter int w_digit    = 6
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [w_bin-1:0]   bin,
    output logic [7:0]         abcdefgh,
    output logic [w_digit-1:0] digit,
    output logic               updated
);

    // ------------------------------------------------------------------
    // Derived constants
    // ------------------------------------------------------------------
    localparam int scan_period = clk_mhz * 1_000_000 / refresh_hz;
    localparam int w_cnt       = (scan_period > 1) ? $clog2(scan_period) : 1;
    localparam int w_idx       = (w_digit > 1) ? $clog2(w_digit) : 1;
    localparam int w_it        = (w_bin > 1) ? $clog2(w_bin) : 1;
    localparam int w_bcd       = 4 * w_digit;

    localparam logic [w_cnt-1:0] cnt_last = w_cnt'(scan_period - 1);
    localparam logic [w_idx-1:0] idx_last = w_idx'(w_digit - 1);
    localparam logic [w_it-1:0]  it_last  = w_it'(w_bin - 1);

    // Elaboration-time sanity checks on the configuration
    generate
        if (scan_period < 2) begin : g_bad_scan_period
            $error("bin_to_dyn_7seg: scan period clk_mhz*1e6/refresh_hz must be >= 2");
        end
        if (w_bin < 1) begin : g_bad_w_bin
            $error("bin_to_dyn_7seg: w_bin must be >= 1");
        end
        if (w_digit < 1) begin : g_bad_w_digit
            $error("bin_to_dyn_7seg: w_digit must be >= 1");
        end
    endgenerate

    // ------------------------------------------------------------------
    // Segment decoder: BCD nibble -> active-high abcdefgh (dp = 0).
    // Nibbles 10..15 cannot come out of the converter and decode blank.
    // ------------------------------------------------------------------
    function automatic logic [7:0] seg_decode(input logic [3:0] nib);
        logic [7:0] seg;
        case (nib)
            4'd0:    seg = 8'hFC;
            4'd1:    seg = 8'h60;
            4'd2:    seg = 8'hDA;
            4'd3:    seg = 8'hF2;
            4'd4:    seg = 8'h66;
            4'd5:    seg = 8'hB6;
            4'd6:    seg = 8'hBE;
            4'd7:    seg = 8'hE0;
            4'd8:    seg = 8'hFE;
            4'd9:    seg = 8'hF6;
            default: seg = 8'h00;
        endcase
        return seg;
    endfunction

    // ------------------------------------------------------------------
    // Converter state
    // ------------------------------------------------------------------
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_LOAD = 2'd2
    } state_t;

    state_t                   state;
    logic [w_bin-1:0]         bin_reg;   // binary half of the shift register
    logic [w_bcd-1:0]         bcd_reg;   // BCD half of the shift register
    logic [w_it-1:0]          it;        // iteration counter within CONV
    logic [w_bcd-1:0]         disp_reg;  // snapshot shown by the scanner

    logic [w_bcd-1:0]         bcd_adj;
    logic [w_bcd+w_bin-1:0]   sh_next;

    // Add-3 correction on every BCD nibble >= 5, then shift {bcd, bin} left.
    // Digits beyond w_digit fall off the top, leaving the value mod 10^w_digit.
    always_comb begin
        // NOTE: every variable gets a default before any conditional
        // assignment so no path leaves it unassigned (no inferred latch).
        bcd_adj = bcd_reg;
        for (int i = 0; i < w_digit; i++) begin
            if (bcd_reg[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd_reg[4*i +: 4] + 4'd3;
            end
        end
        sh_next = {bcd_adj, bin_reg} << 1;
    end

    // Converter FSM: sample in IDLE, iterate in CONV, publish in LOAD.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= S_IDLE;
            bin_reg  <= '0;
            bcd_reg  <= '0;
            it       <= '0;
            disp_reg <= '0;
            updated  <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every
            // register samples the pre-edge values, independent of order.
            updated <= 1'b0;
            case (state)
                S_IDLE: begin
                    bin_reg <= bin;
                    bcd_reg <= '0;
                    it      <= '0;
                    state   <= S_CONV;
                end
                S_CONV: begin
                    {bcd_reg, bin_reg} <= sh_next;
                    it                 <= it + 1'b1;
                    if (it == it_last) begin
                        state <= S_LOAD;
                    end
                end
                S_LOAD: begin
                    disp_reg <= bcd_reg;
                    updated  <= 1'b1;
                    state    <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Scanner
    // ------------------------------------------------------------------
    logic [w_cnt-1:0] cnt;
    logic [w_idx-1:0] idx;
    logic [3:0]       cur_nib;
    logic [7:0]       seg_next;

    // Select the display nibble for the digit currently being scanned.
    always_comb begin
        cur_nib = '0;
        for (int i = 0; i < w_digit; i++) begin
            if (idx == w_idx'(i)) begin
                cur_nib = disp_reg[4*i +: 4];
            end
        end
    end

`ifdef BIN_TO_DYN_7SEG_LEADING_ZERO_BLANK_EN
    logic [w_digit-1:0] blank;
    logic               cur_blank;

    // A digit is blank when it and every digit above it are zero;
    // digit 0 always shows, so a zero value displays a single "0".
    always_comb begin
        logic nz_above;
        nz_above = 1'b0;
        blank    = '0;
        for (int i = w_digit - 1; i >= 0; i--) begin
            nz_above = nz_above | (disp_reg[4*i +: 4] != 4'd0);
            blank[i] = (i != 0) && !nz_above;
        end
    end

    // Blank flag of the digit currently being scanned.
    always_comb begin
        cur_blank = 1'b0;
        for (int i = 0; i < w_digit; i++) begin
            if (idx == w_idx'(i)) begin
                cur_blank = blank[i];
            end
        end
    end

    assign seg_next = cur_blank ? 8'h00 : seg_decode(cur_nib);
`else
    assign seg_next = seg_decode(cur_nib);
`endif

    // Scan counter, digit index and registered display outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt      <= '0;
            idx      <= '0;
            digit    <= '0;
            abcdefgh <= 8'h00;
        end else begin
            digit    <= w_digit'(1) << idx;
            abcdefgh <= seg_next;
            if (cnt == cnt_last) begin
                cnt <= '0;
                idx <= (idx == idx_last) ? '0 : idx + 1'b1;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end

endmodule
